// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch unit with a small circular queue. It issues one word
//   fetch per cycle while queue credit remains, captures each response together
//   with the address it was issued for, and presents {pc, inst} to the execute
//   stage over a valid/ready handshake. A redirect from execute flushes the
//   queue, kills the outstanding request and restarts fetch at the new target.
//
// Parameters
//   DEPTH     number of queue entries (power of 2, 2..16)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-low reset
//   imem_req     fetch request (memory always accepts)
//   imem_addr    word-aligned fetch address
//   imem_rvalid  response valid, one cycle after imem_req
//   imem_rdata   returned instruction word
//   redirect     taken branch/jump from execute: flush and restart
//   redirect_pc  restart address (low two bits ignored)
//   out_valid    {out_pc, out_inst} valid toward execute
//   out_ready    execute accepts the presented entry
//   out_pc       PC of the presented instruction
//   out_inst     presented instruction word
//   count        current queue occupancy
//
// Configuration
//   FETCH_QUEUE_BYPASS_EN  when defined, a live response arriving while the
//                          queue is empty and execute is ready is presented in
//                          the same cycle instead of being written.
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_E = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   tag_q, tag_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic [CW:0]   occupancy;
  logic          live;
  logic          bypass_take;
  logic          push;
  logic          pop;
  logic          q_valid;

  // Handshake and credit. Queue entries plus the outstanding request must
  // never exceed DEPTH; a pop this cycle frees its slot only from next cycle.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path (defaults
    // first), otherwise synthesis infers a latch.
    occupancy   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    imem_req    = rst && !redirect && (occupancy < DEPTH_E);
    imem_addr   = fetch_pc_q;
    // A response is live only if its request survived: inflight_q is cleared
    // by reset and by redirect, and a response landing in a redirect cycle
    // belongs to the squashed path.
    live        = imem_rvalid && inflight_q && !redirect;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_take = live && (count_q == '0) && out_ready;
`else
    bypass_take = 1'b0;
`endif
    push        = live && !bypass_take;
    q_valid     = (count_q != '0) && !redirect;
    pop         = q_valid && out_ready;
    out_valid   = q_valid || bypass_take;
    out_pc      = 32'h0;
    out_inst    = 32'h0;
    if (bypass_take) begin
      out_pc   = tag_q;
      out_inst = imem_rdata;
    end else if (q_valid) begin
      out_pc   = pc_mem[rd_ptr_q];
      out_inst = inst_mem[rd_ptr_q];
    end
    count       = count_q;
  end

  // Next-state for fetch PC, request tag and queue bookkeeping.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_d      = tag_q;
    inflight_d = imem_req;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      // Low two bits are dropped so fetch always stays word aligned.
      fetch_pc_d = redirect_pc & ~32'h3;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (imem_req) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        tag_d      = fetch_pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      tag_q      <= 32'h0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: the storage array has no reset; clearing count_q empties the queue,
  // and entries outside the occupied window are never presented.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= tag_q;
      inst_mem[wr_ptr_q] <= imem_rdata;
    end
  end

  // Credit accounting must make overflow impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Self-checking bench for fetch_queue (DEPTH=4, RESET_PC=0, default build).
//   A small instruction memory answers every request one cycle later with a
//   word derived from the address. A program-order scoreboard records every
//   issued request, is flushed on redirect and reset, and is popped and
//   compared on each accepted output. A table of per-phase records drives the
//   inputs and states the expected observation at the end of each phase; the
//   reset corner cases are written out by hand.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .count      (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Instruction memory: fixed one-cycle response latency.
  always_ff @(posedge clk) begin
    imem_rvalid <= imem_req;
    imem_rdata  <= mem_data(imem_addr);
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_t;

  sb_t         sb[$];
  logic        infl_m;
  logic [31:0] exp_fetch;

  int n_tests = 0;
  int n_fail  = 0;

  logic        obs_req;
  logic [31:0] obs_addr;
  logic        obs_valid;
  logic [31:0] obs_pc;
  logic [2:0]  obs_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    infl_m    = 1'b0;
    exp_fetch = RESET_PC;
  endtask

  // One clock cycle: sample at the falling edge, compare against the model,
  // advance the model for the coming rising edge, return at posedge+1.
  task automatic tick();
    logic       exp_req;
    logic       exp_valid;
    logic [2:0] exp_count;
    sb_t        e;
    @(negedge clk);
    exp_req   = rst && !redirect && (sb.size() < DEPTH);
    exp_count = 3'(sb.size() - int'(infl_m));
    exp_valid = (exp_count != 3'd0) && !redirect;
    check("imem_req", 32'(imem_req), 32'(exp_req));
    check("count", 32'(count), 32'(exp_count));
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_req) check("imem_addr", imem_addr, exp_fetch);
    if (exp_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: output accepted with nothing expected, pc 0x%08h", out_pc);
      end else begin
        e = sb.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_inst", out_inst, e.inst);
      end
    end
    obs_req   = imem_req;
    obs_addr  = imem_addr;
    obs_valid = out_valid;
    obs_pc    = out_pc;
    obs_count = count;
    if (redirect) begin
      sb.delete();
      infl_m    = 1'b0;
      exp_fetch = redirect_pc & ~32'h3;
    end else begin
      if (exp_req) begin
        sb.push_back('{pc: exp_fetch, inst: mem_data(exp_fetch)});
        exp_fetch = exp_fetch + 32'd4;
      end
      infl_m = exp_req;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          n;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [2:0]  e_count;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    // n, rdy, redir, rpc, e_req, e_addr, e_valid, e_pc, e_count
    vecs.push_back('{1,  1'b1, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000, 3'd0}); // first fetch
    vecs.push_back('{1,  1'b1, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h000, 3'd0});
    vecs.push_back('{1,  1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h000, 3'd1}); // N+2 latency
    vecs.push_back('{3,  1'b1, 1'b0, 32'h0,   1'b1, 32'h014, 1'b1, 32'h00C, 3'd1}); // one per cycle
    vecs.push_back('{10, 1'b0, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h010, 3'd4}); // stall fills
    vecs.push_back('{1,  1'b1, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h010, 3'd4}); // pop adds no credit
    vecs.push_back('{1,  1'b1, 1'b0, 32'h0,   1'b1, 32'h020, 1'b1, 32'h014, 3'd3});
    vecs.push_back('{1,  1'b1, 1'b0, 32'h0,   1'b1, 32'h024, 1'b1, 32'h018, 3'd2});
    vecs.push_back('{1,  1'b0, 1'b0, 32'h0,   1'b1, 32'h028, 1'b1, 32'h01C, 3'd2});
    vecs.push_back('{1,  1'b0, 1'b1, 32'h100, 1'b0, 32'h000, 1'b0, 32'h000, 3'd3}); // redirect, 3 + 1 in flight
    vecs.push_back('{1,  1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000, 3'd0}); // flushed
    vecs.push_back('{1,  1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h000, 3'd0}); // dropped response
    vecs.push_back('{1,  1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100, 3'd1});
    vecs.push_back('{1,  1'b1, 1'b1, 32'h203, 1'b0, 32'h000, 1'b0, 32'h000, 3'd1}); // unaligned target
    vecs.push_back('{1,  1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h000, 3'd0});
    vecs.push_back('{1,  1'b1, 1'b1, 32'h040, 1'b0, 32'h000, 1'b0, 32'h000, 3'd0}); // back-to-back
    vecs.push_back('{1,  1'b1, 1'b1, 32'h080, 1'b0, 32'h000, 1'b0, 32'h000, 3'd0});
    vecs.push_back('{1,  1'b1, 1'b0, 32'h0,   1'b1, 32'h080, 1'b0, 32'h000, 3'd0});
    vecs.push_back('{1,  1'b1, 1'b0, 32'h0,   1'b1, 32'h084, 1'b0, 32'h000, 3'd0});
    vecs.push_back('{1,  1'b1, 1'b0, 32'h0,   1'b1, 32'h088, 1'b1, 32'h080, 3'd1}); // first out 0x80
    vecs.push_back('{1,  1'b0, 1'b0, 32'h0,   1'b1, 32'h08C, 1'b1, 32'h084, 3'd1}); // leaves count=2

    rst         = 1'b0;
    out_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("reset imem_req", 32'(imem_req), 32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset count", 32'(count), 32'h0);
    check("reset out_pc", out_pc, 32'h0);
    check("reset out_inst", out_inst, 32'h0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      out_ready   = vecs[i].rdy;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      repeat (vecs[i].n) tick();
      check($sformatf("row%0d req", i), 32'(obs_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req) check($sformatf("row%0d addr", i), obs_addr, vecs[i].e_addr);
      check($sformatf("row%0d valid", i), 32'(obs_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) check($sformatf("row%0d pc", i), obs_pc, vecs[i].e_pc);
      check($sformatf("row%0d count", i), 32'(obs_count), 32'(vecs[i].e_count));
    end
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Mid-stream reset pulse with two entries queued and a response arriving
    // in the same cycle; reset releases before the next edge so that response
    // lands in the first cycle after release and must be discarded.
    rst = 1'b0;
    #1;
    check("async out_valid", 32'(out_valid), 32'h0);
    check("async count", 32'(count), 32'h0);
    check("async imem_req", 32'(imem_req), 32'h0);
    check("async out_pc", out_pc, 32'h0);
    check("async out_inst", out_inst, 32'h0);
    #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    model_reset();
    tick();
    check("post-reset req", 32'(obs_req), 32'h1);
    check("post-reset addr", obs_addr, RESET_PC);
    tick();
    check("stale response dropped", 32'(obs_count), 32'h0);
    check("post-reset addr2", obs_addr, RESET_PC + 32'd4);
    tick();
    check("post-reset first pc", obs_pc, RESET_PC);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
